fighter_anim_ctrl: RTL and testbench

Per-fighter animation sequencer that decides which sprite frame a fighter shows on each video frame. It takes player action requests and a once-per-frame strobe from the VGA timing, runs an action state machine, and outputs a registered `sprite_id`. The sprite drawing path uses `sprite_id` to pick which sprite ROM and palette it reads on the next frame. One instance exists per fighter. All instances run in the VGA clock domain.

---
 rtl/fighter_anim_ctrl_if.sv | 25 ++
 rtl/fighter_anim_ctrl.sv | 131 +++++++++++++
 tb/tb_fighter_anim_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fighter_anim_ctrl_if.sv
// Request/status bundle between a fighter's game logic and its animation sequencer.
interface fighter_anim_ctrl_if;
    logic       frame_start;
    logic       move;
    logic       punch;
    logic       kick;
    logic       hit;
    logic       dead;
    logic [2:0] anim_state;
    logic [1:0] frame_idx;
    logic [3:0] sprite_id;
    logic       hitbox_active;
    logic       busy;
    logic       anim_done;

    modport master (
        output frame_start, move, punch, kick, hit, dead,
        input  anim_state, frame_idx, sprite_id, hitbox_active, busy, anim_done
    );

    modport slave (
        input  frame_start, move, punch, kick, hit, dead,
        output anim_state, frame_idx, sprite_id, hitbox_active, busy, anim_done
    );
endinterface

// File: rtl/fighter_anim_ctrl.sv
// Per-fighter animation sequencer: action FSM, per-frame hold counter and
// registered sprite selection, all in the VGA clock domain.
module fighter_anim_ctrl #(
    parameter int unsigned HOLD = 4
) (
    input  logic               vga_clk,
    input  logic               Reset,
    fighter_anim_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WALK  = 3'd1,
        PUNCH = 3'd2,
        KICK  = 3'd3,
        HIT   = 3'd4,
        DEAD  = 3'd5
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    state_t     state, state_n;
    logic [1:0] frame_idx, frame_idx_n;
    logic [3:0] hold_cnt, hold_cnt_n;
    logic [3:0] sprite_id, sprite_id_n;
    logic       hitbox_active, hitbox_n;
    logic       busy, busy_n;
    logic       anim_done, anim_done_n;
    logic [1:0] last_frame;
    logic       can_start;

    // State, counters and all outputs are registered together.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            state         <= IDLE;
            frame_idx     <= '0;
            hold_cnt      <= '0;
            sprite_id     <= '0;
            hitbox_active <= 1'b0;
            busy          <= 1'b0;
            anim_done     <= 1'b0;
        end else begin
            state         <= state_n;
            frame_idx     <= frame_idx_n;
            hold_cnt      <= hold_cnt_n;
            sprite_id     <= sprite_id_n;
            hitbox_active <= hitbox_n;
            busy          <= busy_n;
            anim_done     <= anim_done_n;
        end
    end

    // Prioritised transitions, hold counting, and the next-cycle outputs.
    always_comb begin
        state_n     = state;
        frame_idx_n = frame_idx;
        hold_cnt_n  = hold_cnt;
        anim_done_n = 1'b0;
        can_start   = (state == IDLE) || (state == WALK);

        case (state)
            PUNCH:   last_frame = 2'd2;
            KICK:    last_frame = 2'd3;
            HIT:     last_frame = 2'd1;
            default: last_frame = 2'd0;
        endcase

        if (state == DEAD) begin
            // Absorbing: only reset leaves.
            state_n = DEAD;
        end else if (bus.dead) begin
            state_n = DEAD;  frame_idx_n = '0; hold_cnt_n = '0;
        end else if (bus.hit && state != HIT) begin
            state_n = HIT;   frame_idx_n = '0; hold_cnt_n = '0;
        end else if (bus.punch && can_start) begin
            state_n = PUNCH; frame_idx_n = '0; hold_cnt_n = '0;
        end else if (bus.kick && can_start) begin
            state_n = KICK;  frame_idx_n = '0; hold_cnt_n = '0;
        end else if (bus.move && state == IDLE) begin
            state_n = WALK;  frame_idx_n = '0; hold_cnt_n = '0;
        end else if (bus.frame_start) begin
            if (hold_cnt == HOLD_LAST) begin
                hold_cnt_n = '0;
                case (state)
                    PUNCH, KICK, HIT: begin
                        if (frame_idx == last_frame) begin
                            state_n     = IDLE;
                            frame_idx_n = '0;
                            anim_done_n = 1'b1;
                        end else begin
                            frame_idx_n = frame_idx + 2'd1;
                        end
                    end
                    WALK: begin
                        if (bus.move) begin
                            frame_idx_n = frame_idx + 2'd1;  // 3 -> 0 by 2-bit wrap
                        end else begin
                            state_n     = IDLE;
                            frame_idx_n = '0;
                        end
                    end
                    default: frame_idx_n = '0;
                endcase
            end else begin
                hold_cnt_n = hold_cnt + 4'd1;
            end
        end

        case (state_n)
            WALK:    sprite_id_n = 4'd1  + 4'(frame_idx_n);
            PUNCH:   sprite_id_n = 4'd5  + 4'(frame_idx_n);
            KICK:    sprite_id_n = 4'd8  + 4'(frame_idx_n);
            HIT:     sprite_id_n = 4'd12 + 4'(frame_idx_n);
            DEAD:    sprite_id_n = 4'd14;
            default: sprite_id_n = 4'd0;
        endcase

        hitbox_n = ((state_n == PUNCH) && (frame_idx_n == 2'd1)) ||
                   ((state_n == KICK)  && (frame_idx_n == 2'd2));
        busy_n   = (state_n == PUNCH) || (state_n == KICK) ||
                   (state_n == HIT)   || (state_n == DEAD);
    end

    assign bus.anim_state    = state;
    assign bus.frame_idx     = frame_idx;
    assign bus.sprite_id     = sprite_id;
    assign bus.hitbox_active = hitbox_active;
    assign bus.busy          = busy;
    assign bus.anim_done     = anim_done;

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// Directed bench for fighter_anim_ctrl with HOLD=4.
module tb_fighter_anim_ctrl;

    logic vga_clk = 1'b0;
    logic Reset   = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    fighter_anim_ctrl_if bus();

    fighter_anim_ctrl #(.HOLD(4)) dut (
        .vga_clk (vga_clk),
        .Reset   (Reset),
        .bus     (bus)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int st, input int fi,
                              input int sp, input int hb, input int bs, input int dn);
        check_val({tag, ".state"},  int'(bus.anim_state),    st);
        check_val({tag, ".frame"},  int'(bus.frame_idx),     fi);
        check_val({tag, ".sprite"}, int'(bus.sprite_id),     sp);
        check_val({tag, ".hitbox"}, int'(bus.hitbox_active), hb);
        check_val({tag, ".busy"},   int'(bus.busy),          bs);
        check_val({tag, ".done"},   int'(bus.anim_done),     dn);
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic strobe();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.move  = 1'b0;
        bus.punch = 1'b0;
        bus.kick  = 1'b0;
        bus.hit   = 1'b0;
        bus.dead  = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        check_outs("reset", 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a punch, then a fresh kick.
        repeat (3) tick();
        bus.punch = 1'b1; tick(); bus.punch = 1'b0;
        check_outs("rst_mid.punch", 2, 0, 5, 0, 1, 0);
        strobe(); strobe();
        do_reset();
        check_outs("rst_mid.after", 0, 0, 0, 0, 0, 0);
        bus.kick = 1'b1; tick(); bus.kick = 1'b0;
        check_outs("kick.start", 3, 0, 8, 0, 1, 0);
        for (int i = 1; i <= 16; i++) begin
            strobe();
            if (i < 16) check_outs("kick.run", 3, i / 4, 8 + i / 4, (i / 4 == 2) ? 1 : 0, 1, 0);
            else        check_outs("kick.end", 0, 0, 0, 0, 0, 1);
        end
        tick();
        check_outs("kick.done_clr", 0, 0, 0, 0, 0, 0);

        // Punch sequence: 5 x4, 6 x4 (hitbox), 7 x4, then IDLE with done.
        bus.punch = 1'b1; tick(); bus.punch = 1'b0;
        check_outs("punch.start", 2, 0, 5, 0, 1, 0);
        for (int i = 1; i <= 12; i++) begin
            strobe();
            if (i < 12) check_outs("punch.run", 2, i / 4, 5 + i / 4, (i / 4 == 1) ? 1 : 0, 1, 0);
            else        check_outs("punch.end", 0, 0, 0, 0, 0, 1);
        end
        tick();
        check_outs("punch.done_clr", 0, 0, 0, 0, 0, 0);

        // Walk loop for 20 strobes, then release move.
        bus.move = 1'b1; tick();
        check_outs("walk.start", 1, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            strobe();
            check_val("walk.sprite", int'(bus.sprite_id), 1 + (i / 4) % 4);
        end
        bus.move = 1'b0; tick();
        check_val("walk.release", int'(bus.anim_state), 1);
        for (int i = 1; i <= 4; i++) begin
            strobe();
            check_val("walk.tail", int'(bus.anim_state), (i < 4) ? 1 : 0);
        end

        // Priority: punch beats kick, kick ignored, hit interrupts, hit not restarted.
        bus.punch = 1'b1; bus.kick = 1'b1; tick(); bus.punch = 1'b0; bus.kick = 1'b0;
        check_outs("prio.both", 2, 0, 5, 0, 1, 0);
        bus.kick = 1'b1; tick(); bus.kick = 1'b0;
        check_outs("prio.kick_ign", 2, 0, 5, 0, 1, 0);
        repeat (4) strobe();
        check_outs("prio.frame1", 2, 1, 6, 1, 1, 0);
        bus.hit = 1'b1; tick(); bus.hit = 1'b0;
        check_outs("prio.hit", 4, 0, 12, 0, 1, 0);
        repeat (4) strobe();
        check_val("prio.hit_f1", int'(bus.sprite_id), 13);
        bus.hit = 1'b1; tick(); bus.hit = 1'b0;
        check_val("prio.rehit", int'(bus.sprite_id), 13);
        for (int i = 1; i <= 4; i++) begin
            strobe();
            if (i < 4) check_val("prio.hit_tail", int'(bus.sprite_id), 13);
            else       check_outs("prio.hit_end", 0, 0, 0, 0, 0, 1);
        end

        // Death during HIT is absorbing.
        bus.hit = 1'b1; tick(); bus.hit = 1'b0;
        check_val("dead.in_hit", int'(bus.anim_state), 4);
        strobe();
        bus.dead = 1'b1; tick(); bus.dead = 1'b0;
        check_outs("dead.enter", 5, 0, 14, 0, 1, 0);
        for (int i = 0; i < 50; i++) begin
            bus.hit = 1'b1; bus.punch = 1'b1; bus.move = 1'b1;
            strobe();
            bus.hit = 1'b0; bus.punch = 1'b0;
            tick();
            check_val("dead.state", int'(bus.anim_state), 5);
            check_val("dead.sprite", int'(bus.sprite_id), 14);
        end
        bus.move = 1'b0;
        do_reset();
        check_outs("dead.reset", 0, 0, 0, 0, 0, 0);

        // Punch coincident with frame_start while walking: hold count restarts.
        bus.move = 1'b1; tick();
        strobe(); strobe();
        bus.punch = 1'b1; bus.frame_start = 1'b1; bus.move = 1'b0;
        tick();
        bus.punch = 1'b0; bus.frame_start = 1'b0;
        check_outs("simul.start", 2, 0, 5, 0, 1, 0);
        for (int i = 1; i <= 4; i++) begin
            strobe();
            check_val("simul.sprite", int'(bus.sprite_id), (i < 4) ? 5 : 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
